// File: rtl/acq_bank_writer.sv
// acq_bank_writer: captures acoustic-emission samples into a two-bank sample
// memory, ping-ponging between banks while the event lasts, and hands each
// filled bank / final partial bank to the downstream serial readout FSM.
module acq_bank_writer #(
    parameter int DEPTH   = 200,  // words per bank, must be <= 256
    parameter int DW      = 16,   // sample width
    parameter int HOLDOFF = 4     // cycles spent in HOLD, must be >= 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ae_active,
    input  logic          sample_valid,
    input  logic [DW-1:0] sample_data,
    input  logic          sending_data,
    output logic          we,
    output logic [8:0]    wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          bank,
    output logic          bank0_full,
    output logic          bank1_full,
    output logic          memorization_completed,
    output logic [7:0]    idx_final,
    output logic [7:0]    dropped_cnt
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WRITE  = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

    localparam logic [7:0] LAST_IDX = 8'(DEPTH - 1);
    localparam int         HW        = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF - 1);

    logic [1:0]    state;
    logic          cur_bank;         // bank the next write goes to
    logic [7:0]    idx;              // index the next write goes to
    logic          wrote_in_bank;    // a word landed in cur_bank since the last toggle
    logic          reject_lock;      // rejected event still active, wait for ae_active low
    logic [HW-1:0] hold_cnt;

    logic start_ok;
    logic reject;
    logic write_fire;
    logic at_last;
    logic finish_partial;

    // An idle block accepts a new event only if readout is free and no rejected
    // event is still in progress; the first sample of the event may arrive with it.
    assign start_ok       = (state == S_IDLE) && ae_active && !sending_data && !reject_lock;
    assign reject         = (state == S_IDLE) && ae_active &&  sending_data && !reject_lock;
    assign write_fire     = sample_valid && (((state == S_WRITE) && ae_active) || start_ok);
    assign at_last        = (idx == LAST_IDX);
    assign finish_partial = (state == S_FINISH) && wrote_in_bank;

    // Control FSM, write pointer, bank ping-pong and rejected-event counter.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register here samples the pre-edge values regardless of statement order.
        if (reset) begin
            state         <= S_IDLE;
            cur_bank      <= 1'b0;
            idx           <= 8'd0;
            wrote_in_bank <= 1'b0;
            reject_lock   <= 1'b0;
            hold_cnt      <= '0;
            dropped_cnt   <= 8'd0;
        end else begin
            if (write_fire) begin
                if (at_last) begin
                    idx           <= 8'd0;
                    cur_bank      <= ~cur_bank;
                    wrote_in_bank <= 1'b0;
                end else begin
                    idx           <= idx + 8'd1;
                    wrote_in_bank <= 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (!ae_active) begin
                        reject_lock <= 1'b0;
                    end
                    if (start_ok) begin
                        state <= S_WRITE;
                    end else if (reject) begin
                        reject_lock <= 1'b1;
                        if (dropped_cnt != 8'hFF) begin
                            dropped_cnt <= dropped_cnt + 8'd1;
                        end
                    end
                end
                S_WRITE: begin
                    if (!ae_active) begin
                        state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    // The partial bank is handed over, so the next event
                    // starts at the top of the other bank.
                    if (wrote_in_bank) begin
                        idx           <= 8'd0;
                        cur_bank      <= ~cur_bank;
                        wrote_in_bank <= 1'b0;
                    end
                    hold_cnt <= '0;
                    state    <= S_HOLD;
                end
                default: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
            endcase
        end
    end

    // Registered memory port, bank indicator and handover pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we                     <= 1'b0;
            wr_addr                <= 9'd0;
            wr_data                <= '0;
            bank                   <= 1'b0;
            bank0_full             <= 1'b0;
            bank1_full             <= 1'b0;
            memorization_completed <= 1'b0;
            idx_final              <= 8'd0;
        end else begin
            we <= write_fire;
            if (write_fire) begin
                wr_addr <= {cur_bank, idx};
                wr_data <= sample_data;
            end
            // bank trails cur_bank by one cycle so it changes together with
            // the full pulse and still names the completed bank at completion.
            bank       <= cur_bank;
            bank0_full <= we && (wr_addr[7:0] == LAST_IDX) && !wr_addr[8];
            bank1_full <= we && (wr_addr[7:0] == LAST_IDX) &&  wr_addr[8];
            memorization_completed <= finish_partial;
            if (finish_partial) begin
                idx_final <= idx - 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_acq_bank_writer.sv
// Directed testbench for acq_bank_writer: short / long / exact-boundary events,
// busy rejection with saturation, simultaneous fall, reset mid-event.
module tb_acq_bank_writer;

    localparam int DEPTH   = 200;
    localparam int DW      = 16;
    localparam int HOLDOFF = 4;

    logic          clk;
    logic          reset;
    logic          ae_active;
    logic          sample_valid;
    logic [DW-1:0] sample_data;
    logic          sending_data;
    logic          we;
    logic [8:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic          bank;
    logic          bank0_full;
    logic          bank1_full;
    logic          memorization_completed;
    logic [7:0]    idx_final;
    logic [7:0]    dropped_cnt;

    int errors = 0;
    int checks = 0;

    // Observed traffic, collected on the falling edge while out of reset.
    logic [8:0]    wa_q[$];
    logic [DW-1:0] wd_q[$];
    int b0_cnt;
    int b1_cnt;
    int mc_cnt;
    int overlap_cnt;

    acq_bank_writer #(.DEPTH(DEPTH), .DW(DW), .HOLDOFF(HOLDOFF)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .ae_active              (ae_active),
        .sample_valid           (sample_valid),
        .sample_data            (sample_data),
        .sending_data           (sending_data),
        .we                     (we),
        .wr_addr                (wr_addr),
        .wr_data                (wr_data),
        .bank                   (bank),
        .bank0_full             (bank0_full),
        .bank1_full             (bank1_full),
        .memorization_completed (memorization_completed),
        .idx_final              (idx_final),
        .dropped_cnt            (dropped_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (we) begin
                wa_q.push_back(wr_addr);
                wd_q.push_back(wr_data);
            end
            if (bank0_full) b0_cnt++;
            if (bank1_full) b1_cnt++;
            if (memorization_completed) mc_cnt++;
            if (memorization_completed && (bank0_full || bank1_full)) overlap_cnt++;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_mon();
        wa_q.delete();
        wd_q.delete();
        b0_cnt = 0;
        b1_cnt = 0;
        mc_cnt = 0;
        overlap_cnt = 0;
    endtask

    task automatic apply_reset();
        reset        = 1'b1;
        ae_active    = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;
        sending_data = 1'b0;
        tick();
        clear_mon();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // n back-to-back samples with ae_active high; data = base + i.
    task automatic send(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            ae_active    = 1'b1;
            sample_valid = 1'b1;
            sample_data  = 16'(base + i);
            tick();
        end
        sample_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (HOLDOFF + 3) tick();
    endtask

    function automatic logic [8:0] exp_addr(input int k, input logic start_bank);
        logic b;
        b = start_bank ^ logic'((k / DEPTH) % 2);
        return {b, 8'(k % DEPTH)};
    endfunction

    task automatic test_reset();
        reset        = 1'b1;
        ae_active    = 1'b1;
        sample_valid = 1'b1;
        sample_data  = 16'hFFFF;
        sending_data = 1'b0;
        repeat (3) tick();
        checks++;
        if ({we, wr_addr, wr_data} !== 26'd0) begin
            errors++;
            $display("FAIL reset_port: we/addr/data=%b/%h/%h, need 0/000/0000", we, wr_addr, wr_data);
        end
        checks++;
        if ({bank, bank0_full, bank1_full, memorization_completed} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: bank/f0/f1/mc=%b%b%b%b, need 0000",
                     bank, bank0_full, bank1_full, memorization_completed);
        end
        checks++;
        if (idx_final !== 8'd0 || dropped_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_counts: idx_final=%0d dropped=%0d, need 0 0", idx_final, dropped_cnt);
        end
        apply_reset();
    endtask

    task automatic test_short_event();
        int bad;
        clear_mon();
        ae_active    = 1'b1;
        sample_valid = 1'b1;
        sample_data  = 16'h1000;
        tick();
        checks++;
        if (we !== 1'b1 || wr_addr !== 9'h000 || wr_data !== 16'h1000) begin
            errors++;
            $display("FAIL short_first_write: we/addr/data=%b/%h/%h, need 1/000/1000", we, wr_addr, wr_data);
        end
        send(49, 16'h1001);
        ae_active = 1'b0;
        tick();
        checks++;
        if (memorization_completed !== 1'b0 || we !== 1'b0) begin
            errors++;
            $display("FAIL short_mc_early: mc=%b we=%b one cycle after fall, need 0 0", memorization_completed, we);
        end
        tick();
        checks++;
        if (memorization_completed !== 1'b1 || idx_final !== 8'd49 || bank !== 1'b0) begin
            errors++;
            $display("FAIL short_complete: mc=%b idx_final=%0d bank=%b, need 1 49 0",
                     memorization_completed, idx_final, bank);
        end
        tick();
        checks++;
        if (memorization_completed !== 1'b0 || idx_final !== 8'd49) begin
            errors++;
            $display("FAIL short_pulse_width: mc=%b idx_final=%0d, need 0 49", memorization_completed, idx_final);
        end
        settle();
        bad = (wa_q.size() == 50) ? 0 : 1;
        for (int k = 0; k < 50 && k < wa_q.size(); k++) begin
            if (wa_q[k] !== exp_addr(k, 1'b0) || wd_q[k] !== 16'(16'h1000 + k)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL short_writes: %0d writes with %0d bad entries, need 50 writes to 000..031", wa_q.size(), bad);
        end
        checks++;
        if (b0_cnt != 0 || b1_cnt != 0 || mc_cnt != 1) begin
            errors++;
            $display("FAIL short_pulses: f0=%0d f1=%0d mc=%0d, need 0 0 1", b0_cnt, b1_cnt, mc_cnt);
        end
    endtask

    // Follows the short event without reset: the next event uses the other bank.
    task automatic test_bank_continue();
        clear_mon();
        send(3, 16'h2000);
        ae_active = 1'b0;
        tick();
        tick();
        checks++;
        if (memorization_completed !== 1'b1 || idx_final !== 8'd2 || bank !== 1'b1) begin
            errors++;
            $display("FAIL continue_complete: mc=%b idx_final=%0d bank=%b, need 1 2 1",
                     memorization_completed, idx_final, bank);
        end
        settle();
        checks++;
        if (wa_q.size() != 3 || wa_q[0] !== 9'h100 || wa_q[2] !== 9'h102) begin
            errors++;
            $display("FAIL continue_addr: %0d writes first=%h, need 3 writes 100..102",
                     wa_q.size(), (wa_q.size() > 0) ? wa_q[0] : 9'h1FF);
        end
    endtask

    task automatic test_long_event();
        int bad;
        apply_reset();
        clear_mon();
        send(450, 16'h3000);
        ae_active = 1'b0;
        tick();
        tick();
        checks++;
        if (memorization_completed !== 1'b1 || idx_final !== 8'd49) begin
            errors++;
            $display("FAIL long_complete: mc=%b idx_final=%0d, need 1 49", memorization_completed, idx_final);
        end
        settle();
        bad = (wa_q.size() == 450) ? 0 : 1;
        for (int k = 0; k < 450 && k < wa_q.size(); k++) begin
            if (wa_q[k] !== exp_addr(k, 1'b0) || wd_q[k] !== 16'(16'h3000 + k)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL long_writes: %0d writes with %0d bad entries, need 450 ping-pong writes", wa_q.size(), bad);
        end
        checks++;
        if (wa_q.size() != 450 || wa_q[400] !== 9'h000 || wa_q[449] !== 9'h031) begin
            errors++;
            $display("FAIL long_tail: write 401 / 450 addresses wrong, need 000 and 031");
        end
        checks++;
        if (b0_cnt != 1 || b1_cnt != 1 || mc_cnt != 1 || overlap_cnt != 0) begin
            errors++;
            $display("FAIL long_pulses: f0=%0d f1=%0d mc=%0d overlap=%0d, need 1 1 1 0",
                     b0_cnt, b1_cnt, mc_cnt, overlap_cnt);
        end
    endtask

    task automatic test_exact_boundary();
        apply_reset();
        clear_mon();
        send(199, 16'h4000);
        ae_active    = 1'b1;
        sample_valid = 1'b1;
        sample_data  = 16'h40C7;
        tick();
        checks++;
        if (we !== 1'b1 || wr_addr !== 9'h0C7 || bank0_full !== 1'b0 || bank !== 1'b0) begin
            errors++;
            $display("FAIL boundary_last_write: we=%b addr=%h f0=%b bank=%b, need 1 0c7 0 0",
                     we, wr_addr, bank0_full, bank);
        end
        sample_valid = 1'b0;
        ae_active    = 1'b0;
        tick();
        checks++;
        if (bank0_full !== 1'b1 || bank !== 1'b1 || memorization_completed !== 1'b0) begin
            errors++;
            $display("FAIL boundary_full: f0=%b bank=%b mc=%b, need 1 1 0", bank0_full, bank, memorization_completed);
        end
        settle();
        checks++;
        if (b0_cnt != 1 || b1_cnt != 0 || mc_cnt != 0 || wa_q.size() != 200) begin
            errors++;
            $display("FAIL boundary_pulses: f0=%0d f1=%0d mc=%0d writes=%0d, need 1 0 0 200",
                     b0_cnt, b1_cnt, mc_cnt, wa_q.size());
        end
    endtask

    task automatic test_busy_reject();
        apply_reset();
        clear_mon();
        sending_data = 1'b1;
        for (int p = 0; p < 3; p++) begin
            ae_active    = 1'b1;
            sample_valid = 1'b1;
            repeat (3) tick();
            ae_active    = 1'b0;
            sample_valid = 1'b0;
            repeat (2) tick();
        end
        checks++;
        if (dropped_cnt !== 8'd3 || wa_q.size() != 0) begin
            errors++;
            $display("FAIL busy_three: dropped=%0d writes=%0d, need 3 0", dropped_cnt, wa_q.size());
        end
        // Readout frees up while the rejected event is still active.
        ae_active    = 1'b1;
        sample_valid = 1'b1;
        tick();
        sending_data = 1'b0;
        repeat (3) tick();
        ae_active    = 1'b0;
        sample_valid = 1'b0;
        tick();
        checks++;
        if (dropped_cnt !== 8'd4 || wa_q.size() != 0) begin
            errors++;
            $display("FAIL busy_lock: dropped=%0d writes=%0d, need 4 0", dropped_cnt, wa_q.size());
        end
        sending_data = 1'b1;
        for (int p = 0; p < 300; p++) begin
            ae_active = 1'b1;
            tick();
            ae_active = 1'b0;
            tick();
        end
        checks++;
        if (dropped_cnt !== 8'd255) begin
            errors++;
            $display("FAIL busy_saturate: dropped=%0d, need 255", dropped_cnt);
        end
        sending_data = 1'b0;
    endtask

    task automatic test_simultaneous();
        apply_reset();
        clear_mon();
        send(5, 16'h5000);
        sending_data = 1'b1;  // ignored outside IDLE
        send(5, 16'h5005);
        ae_active    = 1'b0;
        sample_valid = 1'b1;
        sample_data  = 16'hDEAD;
        tick();
        sample_valid = 1'b0;
        checks++;
        if (we !== 1'b0) begin
            errors++;
            $display("FAIL simul_discard: we=%b after falling-edge sample, need 0", we);
        end
        tick();
        checks++;
        if (memorization_completed !== 1'b1 || idx_final !== 8'd9) begin
            errors++;
            $display("FAIL simul_complete: mc=%b idx_final=%0d, need 1 9", memorization_completed, idx_final);
        end
        settle();
        sending_data = 1'b0;
        checks++;
        if (wa_q.size() != 10 || wa_q[9] !== 9'h009 || wd_q[9] !== 16'h5009) begin
            errors++;
            $display("FAIL simul_writes: %0d writes, need 10 ending at 009 with 5009", wa_q.size());
        end
    endtask

    task automatic test_reset_mid_event();
        apply_reset();
        send(120, 16'h6000);
        ae_active    = 1'b1;
        sample_valid = 1'b1;
        reset        = 1'b1;
        #1;
        checks++;
        if ({we, wr_addr, bank, bank0_full, bank1_full, memorization_completed, idx_final} !== 23'd0) begin
            errors++;
            $display("FAIL reset_mid: we=%b addr=%h bank=%b f0=%b f1=%b mc=%b idx_final=%0d, need all 0",
                     we, wr_addr, bank, bank0_full, bank1_full, memorization_completed, idx_final);
        end
        tick();
        clear_mon();
        ae_active    = 1'b0;
        sample_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        send(5, 16'h7000);
        ae_active = 1'b0;
        tick();
        tick();
        checks++;
        if (memorization_completed !== 1'b1 || idx_final !== 8'd4) begin
            errors++;
            $display("FAIL reset_next_complete: mc=%b idx_final=%0d, need 1 4", memorization_completed, idx_final);
        end
        settle();
        checks++;
        if (wa_q.size() != 5 || wa_q[0] !== 9'h000 || wa_q[4] !== 9'h004 || mc_cnt != 1) begin
            errors++;
            $display("FAIL reset_next_writes: %0d writes mc=%0d, need 5 writes 000..004 and 1 pulse",
                     wa_q.size(), mc_cnt);
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_short_event();
        test_bank_continue();
        test_long_event();
        test_exact_boundary();
        test_busy_reject();
        test_simultaneous();
        test_reset_mid_event();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
